// File: rtl/fb_pkg.sv
// Shared constants for the 320x200, 4 bpp framebuffer writer and the display side.
// Opcodes, geometry, FSM encoding and the nibble merge helper.
package fb_pkg;

  localparam logic OP_PLOT  = 1'b0;
  localparam logic OP_CLEAR = 1'b1;

  localparam int LINE_BYTES = 160;
  localparam int FB_LINES   = 200;
  localparam int FB_BYTES   = 32000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RD   = 3'd2,
    ST_MOD  = 3'd3,
    ST_WR   = 3'd4,
    ST_CLR  = 3'd5
  } fb_state_e;

  // Even pixels live in the high nibble, odd pixels in the low nibble.
  function automatic logic [7:0] merge_nibble(input logic [7:0] old_byte,
                                              input logic [3:0] color,
                                              input logic       hi);
    return hi ? {color, old_byte[3:0]} : {old_byte[7:4], color};
  endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Combinational pixel-to-byte mapping for 160-byte lines: address, nibble select
// and range check. Shared with the display fetch logic.
module fb_addr_calc #(
  parameter logic [14:0] FB_BASE    = 15'd0,
  parameter int          LINE_BYTES = 160,
  parameter int          FB_LINES   = 200
) (
  input  logic [8:0]  x_i,
  input  logic [7:0]  y_i,
  output logic [14:0] addr_o,
  output logic        nib_hi_o,
  output logic        in_range_o
);

  // Y*160 as two shifts keeps this a pair of adders with no multiplier.
  always_comb begin
    addr_o     = FB_BASE + {y_i, 7'd0} + {2'd0, y_i, 5'd0} + {7'd0, x_i[8:1]};
    nib_hi_o   = ~x_i[0];
    in_range_o = (10'(x_i) < 10'(2 * LINE_BYTES)) && (9'(y_i) < 9'(FB_LINES));
  end

endmodule

// File: rtl/fb_writer.sv
// Framebuffer writer: nibble PLOT via read-modify-write and whole-buffer CLEAR,
// sharing the video memory bus only while BUS_GNT is high.
module fb_writer #(
  parameter logic [14:0] FB_BASE    = 15'd0,
  parameter int          LINE_BYTES = fb_pkg::LINE_BYTES,
  parameter int          FB_LINES   = fb_pkg::FB_LINES
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_OP,
  input  logic [8:0]  CMD_X,
  input  logic [7:0]  CMD_Y,
  input  logic [3:0]  CMD_COLOR,
  output logic        BUS_REQ,
  input  logic        BUS_GNT,
  output logic [14:0] ADDR,
  output logic        RW,
  input  logic [7:0]  DIN,
  output logic [7:0]  DOUT,
  output logic        BUSY,
  output logic        ERR
);
  import fb_pkg::*;

  localparam logic [14:0] LAST_N = 15'(LINE_BYTES * FB_LINES - 1);

  fb_state_e   state_q, state_d;
  logic        op_q;
  logic [8:0]  x_q;
  logic [7:0]  y_q;
  logic [3:0]  color_q;
  logic [14:0] addr_q;
  logic [7:0]  dout_q;
  logic [14:0] n_q;
  logic        err_q;
  logic        rdy_q;

  logic        accept;
  logic [8:0]  calc_x;
  logic [7:0]  calc_y;
  logic [14:0] calc_addr;
  logic        nib_hi;
  logic        in_range;

  // In IDLE the mapper looks at the live command for the range check;
  // otherwise it serves the registered pixel.
  assign calc_x = (state_q == ST_IDLE) ? CMD_X : x_q;
  assign calc_y = (state_q == ST_IDLE) ? CMD_Y : y_q;
  assign accept = CMD_VALID && CMD_READY;

  fb_addr_calc #(
    .FB_BASE    (FB_BASE),
    .LINE_BYTES (LINE_BYTES),
    .FB_LINES   (FB_LINES)
  ) u_addr_calc (
    .x_i        (calc_x),
    .y_i        (calc_y),
    .addr_o     (calc_addr),
    .nib_hi_o   (nib_hi),
    .in_range_o (in_range)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Any grant loss inside the read-modify-write restarts from a fresh read.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && (CMD_OP == OP_CLEAR || in_range)) state_d = ST_REQ;
      ST_REQ:  if (BUS_GNT) state_d = (op_q == OP_CLEAR) ? ST_CLR : ST_RD;
      ST_RD:   state_d = BUS_GNT ? ST_MOD  : ST_REQ;
      ST_MOD:  state_d = BUS_GNT ? ST_WR   : ST_REQ;
      ST_WR:   state_d = BUS_GNT ? ST_IDLE : ST_REQ;
      ST_CLR:  if (BUS_GNT && n_q == LAST_N) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    CMD_READY = (state_q == ST_IDLE) && rdy_q;
    BUSY      = (state_q != ST_IDLE);
    BUS_REQ   = (state_q != ST_IDLE);
    RW        = !(BUS_GNT && (state_q == ST_WR || state_q == ST_CLR));
    ADDR      = addr_q;
    DOUT      = dout_q;
    ERR       = err_q;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      op_q    <= OP_PLOT;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      n_q     <= '0;
    end else begin
      rdy_q <= 1'b1;
      err_q <= accept && (CMD_OP == OP_PLOT) && !in_range;
      if (accept) begin
        op_q    <= CMD_OP;
        x_q     <= CMD_X;
        y_q     <= CMD_Y;
        color_q <= CMD_COLOR;
      end
      case (state_q)
        ST_REQ: begin
          if (BUS_GNT) begin
            if (op_q == OP_CLEAR) begin
              addr_q <= FB_BASE;
              n_q    <= '0;
              dout_q <= {color_q, color_q};
            end else begin
              addr_q <= calc_addr;
            end
          end
        end
        ST_MOD: if (BUS_GNT) dout_q <= merge_nibble(DIN, color_q, nib_hi);
        // The address stops on the last byte rather than stepping past it.
        ST_CLR: begin
          if (BUS_GNT && n_q != LAST_N) begin
            n_q    <= n_q + 15'd1;
            addr_q <= addr_q + 15'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
